mem_controller: RTL

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_controller.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_controller.sv
// mem_controller: byte-serial RAM access engine shared by the LSB and fetch.
// Data ops win over fetch; each op ends with a single completion pulse.
module mem_controller (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        request,
  input  logic        load_or_store,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_valid,
  output logic [31:0] mem_val,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  localparam logic [5:0] LB  = 6'd1;
  localparam logic [5:0] LH  = 6'd2;
  localparam logic [5:0] LW  = 6'd3;
  localparam logic [5:0] LBU = 6'd4;
  localparam logic [5:0] LHU = 6'd5;
  localparam logic [5:0] SB  = 6'd6;
  localparam logic [5:0] SH  = 6'd7;
  localparam logic [5:0] SW  = 6'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_FETCH,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_val_q, mem_val_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        fetch_q, fetch_d;
  logic        clr_q, clr_d;

  logic [2:0]  nbytes;
  logic [31:0] cur_a;
  logic        stall;
  logic [1:0]  kp;
  logic [31:0] ext;
  logic        wr;

  assign cur_a = addr_q + {29'd0, k_q};
  assign stall = io_buffer_full && (addr_q[17:16] == 2'b11);
  assign kp    = 2'(k_q - 3'd1);

  // Byte count of the latched operation
  always_comb begin
    nbytes = 3'd4;
    case (op_q)
      LB, LBU, SB: nbytes = 3'd1;
      LH, LHU, SH: nbytes = 3'd2;
      default:     nbytes = 3'd4;
    endcase
  end

  // Sign/zero extension of the assembled load word
  always_comb begin
    ext = buf_d;
    case (op_q)
      LB:      ext = {{24{buf_d[7]}}, buf_d[7:0]};
      LH:      ext = {{16{buf_d[15]}}, buf_d[15:0]};
      LBU:     ext = {24'd0, buf_d[7:0]};
      LHU:     ext = {16'd0, buf_d[15:0]};
      default: ext = buf_d;
    endcase
  end

  // Next-state, datapath and RAM-side outputs
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    buf_d     = buf_q;
    mem_val_d = mem_val_q;
    if_inst_d = if_inst_q;
    fetch_d   = fetch_q;
    clr_d     = clr_q;
    ram_a     = 32'd0;
    ram_dout  = 8'd0;
    wr        = 1'b0;
    mem_valid = 1'b0;
    if_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        k_d   = 3'd0;
        clr_d = 1'b0;
        if (request) begin
          state_d = load_or_store ? S_STORE : S_LOAD;
          op_d    = mem_op;
          addr_d  = mem_addr;
          data_d  = mem_data;
          fetch_d = 1'b0;
        end else if (if_req) begin
          state_d = S_FETCH;
          op_d    = LW;
          addr_d  = if_addr;
          fetch_d = 1'b1;
        end
      end
      S_LOAD, S_FETCH: begin
        ram_a = cur_a;
        if (k_q != 3'd0) begin
          buf_d[{kp, 3'b000} +: 8] = ram_din;
        end
        if (clear) begin
          state_d = S_IDLE;
          k_d     = 3'd0;
        end else if (k_q == nbytes) begin
          state_d = S_DONE;
          k_d     = 3'd0;
          if (fetch_q) begin
            if_inst_d = buf_d;
          end else begin
            mem_val_d = ext;
          end
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_STORE: begin
        ram_a    = cur_a;
        ram_dout = data_q[{k_q[1:0], 3'b000} +: 8];
        wr       = !stall;
        if (clear) begin
          clr_d = 1'b1;
        end
        if (!stall) begin
          if (k_q == nbytes - 3'd1) begin
            state_d = (clr_q || clear) ? S_IDLE : S_DONE;
            k_d     = 3'd0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        mem_valid = !fetch_q && !(clear && rdy_in);
        if_valid  = fetch_q && !(clear && rdy_in);
        state_d   = S_IDLE;
        k_d       = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = 3'd0;
      end
    endcase
  end

  assign ram_wr  = wr && rdy_in;
  assign mem_val = mem_val_q;
  assign if_inst = if_inst_q;

  // State registers; reset overrides the rdy_in freeze
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      k_q       <= 3'd0;
      op_q      <= 6'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      buf_q     <= 32'd0;
      mem_val_q <= 32'd0;
      if_inst_q <= 32'd0;
      fetch_q   <= 1'b0;
      clr_q     <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      k_q       <= k_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      buf_q     <= buf_d;
      mem_val_q <= mem_val_d;
      if_inst_q <= if_inst_d;
      fetch_q   <= fetch_d;
      clr_q     <= clr_d;
    end
  end

endmodule
